jcsa_seq_adder: RTL and testbench

- Multi-cycle wide adder. It is the sequencing stage that feeds the team's 8-bit carry-skip adder (jcarryskipadder).
- Accepts WIDTH-bit operands over a valid/ready handshake.
- Streams them LSB-first through one 8-bit carry-skip slice per cycle, chaining the slice carry-out through a register.
- Presents the assembled WIDTH-bit sum, carry-out and signed overflow over an output valid/ready handshake.
- Trades latency for area: one 8-bit adder serves any WIDTH.

---
 rtl/jcsa_pkg.sv | 18 +
 rtl/jcarryskipadder.sv | 36 +++
 rtl/jcsa_seq_adder.sv | 154 +++++++++++++++
 tb/tb_jcsa_seq_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jcsa_pkg.sv
// Shared constants, state encoding and sizing helper for the sequential carry-skip adder.
// Imported by jcsa_seq_adder and jcarryskipadder.
package jcsa_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } jcsa_state_e;

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/jcarryskipadder.sv
// 8-bit carry-skip adder: two 4-bit ripple blocks, each with a block-propagate bypass
// of its carry-in to its carry-out.
module jcarryskipadder
    import jcsa_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c_o
);

    localparam int unsigned BlkW = 4;
    localparam int unsigned NBlk = SLICE_W / BlkW;

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    always_comb begin
        p    = a_i ^ b_i;
        g    = a_i & b_i;
        c    = '0;
        c[0] = c_i;
        for (int blk = 0; blk < NBlk; blk++) begin
            for (int i = 0; i < BlkW; i++) begin
                c[blk*BlkW+i+1] = g[blk*BlkW+i] | (p[blk*BlkW+i] & c[blk*BlkW+i]);
            end
            // Fully-propagating block passes its carry-in straight through.
            c[blk*BlkW+BlkW] = c[blk*BlkW+BlkW] | ((&p[blk*BlkW +: BlkW]) & c[blk*BlkW]);
        end
        s_o = p ^ c[SLICE_W-1:0];
        c_o = c[SLICE_W];
    end

endmodule

// File: rtl/jcsa_seq_adder.sv
// Multi-cycle WIDTH-bit adder streaming operands LSB-first through one 8-bit carry-skip slice.
// Define JCSA_SEQ_SUB_EN to add a 'sub' input that turns the operation into A-B.
module jcsa_seq_adder
    import jcsa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef JCSA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NSLICE - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $error("jcsa_seq_adder: WIDTH must be a non-zero multiple of 8");
    end

    jcsa_state_e      state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cr_q, cr_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic [WIDTH-1:0]   res_shift;

`ifdef JCSA_SEQ_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    jcarryskipadder u_slice (
        .a_i (op_a_q[SLICE_W-1:0]),
        .b_i (op_b_q[SLICE_W-1:0]),
        .c_i (cr_q),
        .s_o (slice_sum),
        .c_o (slice_cout)
    );

    // Slices enter from the top so the last one lands in the MSBs.
    if (NSLICE == 1) begin : g_res_one
        assign res_shift = slice_sum;
    end else begin : g_res_many
        assign res_shift = {slice_sum, res_q[WIDTH-1:SLICE_W]};
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        cr_d     = cr_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_a_d   = a;
                    op_b_d   = b_eff;
                    cr_d     = cin_eff;
                    cnt_d    = '0;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b_eff[WIDTH-1];
                    state_d  = StRun;
                end
            end
            StRun: begin
                op_a_d = op_a_q >> SLICE_W;
                op_b_d = op_b_q >> SLICE_W;
                res_d  = res_shift;
                cr_d   = slice_cout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    sum_d   = res_shift;
                    cout_d  = slice_cout;
                    ovf_d   = (sign_a_q == sign_b_q) && (res_shift[WIDTH-1] != sign_a_q);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            cr_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            cr_q     <= cr_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_jcsa_seq_adder.sv
// Self-checking bench for jcsa_seq_adder (WIDTH=32): cycle model plus directed literal vectors.
module tb_jcsa_seq_adder;

    localparam int unsigned W      = 32;
    localparam int unsigned NSLICE = W / 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a_r       = '0;
    logic [W-1:0]  b_r       = '0;
    logic          cin_r     = 1'b0;
    logic          sub_r     = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    jcsa_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_r),
        .b         (b_r),
        .cin       (cin_r),
`ifdef JCSA_SEQ_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {overflow, cout, sum}.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
        logic [W-1:0] ye;
        logic         ce;
        logic [W:0]   t;
        ye = s ? ~y : y;
        ce = s ? 1'b1 : c;
        t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
        return {(x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]), t};
    endfunction

    // Transaction-level model: 0 idle, 1 computing (NSLICE cycles), 2 result offered.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W+1:0] m_pend  = '0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         sub_eff;

`ifdef JCSA_SEQ_SUB_EN
    assign sub_eff = sub_r;
`else
    assign sub_eff = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  <= model_op(a_r, b_r, cin_r, sub_eff);
                    m_left  <= NSLICE;
                    m_phase <= 1;
                end
                1: if (m_left == 1) begin
                    m_sum   <= m_pend[W-1:0];
                    m_cout  <= m_pend[W];
                    m_ovf   <= m_pend[W+1];
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready", W'(in_ready), W'(m_phase == 0));
        check("cyc_out_valid", W'(out_valid), W'(m_phase == 2));
        check("cyc_sum", sum, m_sum);
        check("cyc_cout", W'(cout), W'(m_cout));
        check("cyc_overflow", W'(overflow), W'(m_ovf));
    end

    // Called at a negedge; returns after out_valid seen, lat = posedges after the accept edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic ts, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", W'(in_ready), W'(1));
        a_r      = ta;
        b_r      = tb_v;
        cin_r    = tc;
        sub_r    = ts;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done_wait", W'(out_valid), W'(1));
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] es, input logic ec,
                              input logic eo);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, W'(cout), W'(ec));
        check({name, "_ovf"}, W'(overflow), W'(eo));
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_take", W'(in_ready), W'(1));
    endtask

    initial begin
        int lat;
        int guard;
        repeat (2) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(0));
        check("rst_ovf", W'(overflow), W'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        check("latency", W'(lat), W'(4));
        expect_res("wrap", 32'h0000_0000, 1'b1, 1'b0);
        take_result();
        check("sum_retained", sum, 32'h0000_0000);
        check("cout_retained", W'(cout), W'(1));

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        expect_res("posovf", 32'h8000_0000, 1'b0, 1'b1);
        take_result();

        run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, lat);
        expect_res("ripple", 32'h2143_6588, 1'b0, 1'b0);
        take_result();

        // Backpressure: new operands presented while the result waits.
        run_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, lat);
        a_r      = 32'hDEAD_BEEF;
        b_r      = 32'h0101_0101;
        cin_r    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_sum_held", sum, 32'h3333_3333);
            check("bp_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle", W'(in_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", W'(in_ready), W'(0));
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_done_wait", W'(out_valid), W'(1));
        expect_res("bp_new", 32'hDFAE_BFF0, 1'b0, 1'b0);
        take_result();

        // Reset after two RUN cycles discards the operation.
        a_r      = 32'h0F0F_0F0F;
        b_r      = 32'h1234_5678;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_sum", sum, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd3, 32'd4, 1'b0, 1'b0, lat);
        expect_res("after_rst", 32'd7, 1'b0, 1'b0);
        take_result();

`ifdef JCSA_SEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, lat);
        expect_res("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
        take_result();
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, lat);
        expect_res("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
        take_result();
        sub_r = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
